// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core with a single shared word memory port.
// Sequence per instruction: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The memory port outputs are registered, so addr/we/wdata are held
// constant for as long as a transfer is outstanding.
// Memory handshake: a transfer is outstanding while mem_req=1. It completes
// on the rising edge where mem_req=1 and mem_ready=1. mem_addr, mem_we and
// mem_wdata stay stable until that edge. mem_ready is ignored while mem_req=0.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned MEM_AW   = 30,
  parameter bit          HALT_ILL = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_dbg,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state, state_n;

  logic [31:0] pc, pc_n;
  logic [31:0] ir;
  logic [31:0] a_q, b_q;
  logic [31:0] alu_out, alu_res;
  logic [31:0] mdr;
  logic [31:0] gpr [32];

  logic              req_n, we_n;
  logic [MEM_AW-1:0] addr_n;
  logic [31:0]       wdata_n;
  logic              ir_load, ab_load, alu_load, mdr_load, gpr_we;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sext, zext, br_off, j_target;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign sext     = {{16{imm[15]}}, imm};
  assign zext     = {16'h0000, imm};
  assign br_off   = {sext[29:0], 2'b00};
  assign j_target = {pc[31:28], ir[25:0], 2'b00};

  logic is_r, r_alu, r_nop, is_addiu, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_bne, is_j, legal, taken;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_en;

  // Opcode/funct decode, legality and writeback selection
  always_comb begin
    is_r     = (op == 6'h00);
    r_alu    = is_r && (funct == 6'h21 || funct == 6'h23 || funct == 6'h24 ||
                        funct == 6'h25 || funct == 6'h2A);
    r_nop    = is_r && (funct == 6'h00);
    is_addiu = (op == 6'h09);
    is_ori   = (op == 6'h0D);
    is_lui   = (op == 6'h0F);
    is_lw    = (op == 6'h23);
    is_sw    = (op == 6'h2B);
    is_beq   = (op == 6'h04);
    is_bne   = (op == 6'h05);
    is_j     = (op == 6'h02);
    legal    = r_alu || r_nop || is_addiu || is_ori || is_lui || is_lw ||
               is_sw || is_beq || is_bne || is_j;
    taken    = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    wb_dest  = is_r ? rd : rt;
    wb_data  = is_lw ? mdr : alu_out;
    // An illegal instruction that reaches WB (HALT_ILL=0) writes nothing.
    wb_en    = (r_alu || is_addiu || is_ori || is_lui || is_lw) && (wb_dest != 5'd0);
  end

  // ALU: R-type by funct, immediates by opcode; lw/sw use the add path
  always_comb begin
    alu_res = 32'h0;
    if (is_r) begin
      case (funct)
        6'h21:   alu_res = a_q + b_q;
        6'h23:   alu_res = a_q - b_q;
        6'h24:   alu_res = a_q & b_q;
        6'h25:   alu_res = a_q | b_q;
        6'h2A:   alu_res = {31'h0, ($signed(a_q) < $signed(b_q))};
        default: alu_res = 32'h0;
      endcase
    end else if (is_ori) begin
      alu_res = a_q | zext;
    end else if (is_lui) begin
      alu_res = {imm, 16'h0000};
    end else begin
      alu_res = a_q + sext;
    end
  end

  // Next state, PC update, memory-port next values and datapath strobes
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_n    = mem_req;
    we_n     = mem_we;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    ir_load  = 1'b0;
    ab_load  = 1'b0;
    alu_load = 1'b0;
    mdr_load = 1'b0;
    gpr_we   = 1'b0;
    case (state)
      FETCH: begin
        if (!mem_req) begin
          // Only after reset: the request is raised one cycle into FETCH.
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = pc[MEM_AW+1:2];
        end else if (mem_ready) begin
          ir_load = 1'b1;
          pc_n    = pc + 32'd4;
          req_n   = 1'b0;
          state_n = DECODE;
        end
      end
      DECODE: begin
        ab_load = 1'b1;
        if (!legal && HALT_ILL) state_n = HALT;
        else                    state_n = EXEC;
      end
      EXEC: begin
        alu_load = 1'b1;
        if (is_beq || is_bne || is_j) begin
          if (is_j)       pc_n = j_target;
          else if (taken) pc_n = pc + br_off;
          state_n = FETCH;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = pc_n[MEM_AW+1:2];
        end else if (is_lw || is_sw) begin
          state_n = MEM;
          req_n   = 1'b1;
          we_n    = is_sw;
          addr_n  = alu_res[MEM_AW+1:2];
          wdata_n = b_q;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        if (mem_ready) begin
          we_n = 1'b0;
          if (is_lw) begin
            mdr_load = 1'b1;
            req_n    = 1'b0;
            state_n  = WB;
          end else begin
            // Store done: next fetch request follows back-to-back.
            req_n   = 1'b1;
            addr_n  = pc[MEM_AW+1:2];
            state_n = FETCH;
          end
        end
      end
      WB: begin
        gpr_we  = wb_en;
        req_n   = 1'b1;
        we_n    = 1'b0;
        addr_n  = pc[MEM_AW+1:2];
        state_n = FETCH;
      end
      HALT: begin
        req_n = 1'b0;
        we_n  = 1'b0;
      end
      default: state_n = FETCH;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= FETCH;
    else        state <= state_n;
  end

  // Datapath, register file and memory-port registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc        <= {RESET_PC[31:2], 2'b00};
      ir        <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out   <= 32'h0;
      mdr       <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
    end else begin
      pc        <= pc_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      if (ir_load)  ir      <= mem_rdata;
      if (ab_load) begin
        a_q <= (rs == 5'd0) ? 32'h0 : gpr[rs];
        b_q <= (rt == 5'd0) ? 32'h0 : gpr[rt];
      end
      if (alu_load) alu_out <= alu_res;
      if (mdr_load) mdr     <= mem_rdata;
      if (gpr_we)   gpr[wb_dest] <= wb_data;
    end
  end

  assign halted    = (state == HALT);
  assign pc_dbg    = pc;
  assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a variable-latency memory
// responder for the main core (HALT_ILL=1) and a zero-wait one for a second
// core built with HALT_ILL=0.
module tb_mips_multicycle_core;

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Reset;
  int   cyc;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main DUT ----------------
  logic        mem_req, mem_we, mem_ready, halted;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc_dbg;
  logic [2:0]  state_dbg;

  mips_multicycle_core dut (
    .Clk(Clk), .Reset(Reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .pc_dbg(pc_dbg), .state_dbg(state_dbg)
  );

  // ---------------- second DUT, illegal opcode as NOP ----------------
  logic        mem_req2, mem_we2, mem_ready2, halted2;
  logic [29:0] mem_addr2;
  logic [31:0] mem_wdata2, mem_rdata2, pc_dbg2;
  logic [2:0]  state_dbg2;

  mips_multicycle_core #(.HALT_ILL(1'b0)) dut_nop (
    .Clk(Clk), .Reset(Reset),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .halted(halted2), .pc_dbg(pc_dbg2), .state_dbg(state_dbg2)
  );

  // ---------------- memory model / logs ----------------
  logic [31:0] mem [4096];
  logic [31:0] prog2 [4];
  int          instr_lat, data_lat;
  int          stable_err;
  logic [63:0] wr_q [$];
  logic [29:0] rd_addr_q [$];
  int          rd_cyc_q [$];
  logic [29:0] w2_addr;
  logic [31:0] w2_data;

  // Main responder: ready after lat wait cycles; logs every completed transfer
  initial begin
    int          wait_cnt;
    int          lat;
    logic [29:0] h_addr;
    logic        h_we;
    logic [31:0] h_wdata;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    stable_err = 0;
    wait_cnt   = 0;
    forever begin
      @(negedge Clk);
      if (!Reset || !mem_req || mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = 0;
      end
      if (Reset && mem_req) begin
        if (wait_cnt == 0) begin
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
          stable_err++;
        end
        lat = (mem_addr < 30'h400) ? data_lat : instr_lat;
        if (wait_cnt >= lat) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem[mem_addr[11:0]] = mem_wdata;
            wr_q.push_back({2'b00, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem[mem_addr[11:0]];
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Second responder: always ready, program ROM plus last-write capture
  initial begin
    mem_ready2 = 1'b1;
    mem_rdata2 = 32'h0;
    w2_addr    = '1;
    w2_data    = 32'h0;
    prog2[0] = 32'h34010055;  // ori  $1,$0,0x55
    prog2[1] = 32'hFC000000;  // illegal -> NOP
    prog2[2] = 32'hAC010010;  // sw   $1,16($0)
    prog2[3] = 32'h1000FFFF;  // beq  $0,$0,-1
    forever begin
      @(negedge Clk);
      mem_rdata2 = prog2[mem_addr2[1:0]];
      if (Reset && mem_req2 && mem_we2) begin
        w2_addr = mem_addr2;
        w2_data = mem_wdata2;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  int          total, bad;
  logic [63:0] exp_q [$];
  logic [29:0] exp_rd_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  function automatic int find_rd(input logic [29:0] a);
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [29:0] rd_at(input int i);
    if (i < 0 || i >= rd_addr_q.size()) return '1;
    return rd_addr_q[i];
  endfunction

  function automatic int cyc_at(input int i);
    if (i < 0 || i >= rd_cyc_q.size()) return -1000;
    return rd_cyc_q[i];
  endfunction

  task automatic clear_logs();
    wr_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, n, idx, req_hi;
    total = 0;
    bad   = 0;
    Reset = 1'b0;
    instr_lat = 1000;
    data_lat  = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    // program A at byte 0x3000 (word 0xC00)
    mem[12'hC00] = 32'h34011234;  // ori  $1,$0,0x1234
    mem[12'hC01] = 32'h3C02ABCD;  // lui  $2,0xABCD
    mem[12'hC02] = 32'h00221821;  // addu $3,$1,$2
    mem[12'hC03] = 32'hAC030008;  // sw   $3,8($0)
    mem[12'hC04] = 32'h8C040008;  // lw   $4,8($0)
    mem[12'hC05] = 32'hAC04000C;  // sw   $4,12($0)
    mem[12'hC06] = 32'hFC000000;  // illegal -> HALT
    tick(2);

    // reset state
    chk("rst_req",   {63'h0, mem_req}, 64'h0);
    chk("rst_we",    {63'h0, mem_we}, 64'h0);
    chk("rst_addr",  {34'h0, mem_addr}, 64'h0);
    chk("rst_wdata", {32'h0, mem_wdata}, 64'h0);
    chk("rst_halt",  {63'h0, halted}, 64'h0);
    chk("rst_pc",    {32'h0, pc_dbg}, 64'h3000);
    chk("rst_state", {61'h0, state_dbg}, 64'h0);

    // first fetch stalls; reset mid-transfer drops req at once
    Reset = 1'b1;
    k = 0;
    while (!mem_req && k < 10) begin tick(1); k++; end
    chk("fetch_req_up", {63'h0, mem_req}, 64'h1);
    chk("fetch_addr",   {34'h0, mem_addr}, 64'hC00);
    tick(2);
    chk("fetch_stall",  {63'h0, mem_req}, 64'h1);
    Reset = 1'b0;
    #1;
    chk("req_drop_async", {63'h0, mem_req}, 64'h0);
    tick(1);
    clear_logs();
    instr_lat = 0;
    data_lat  = 3;
    Reset = 1'b1;
    chk("pc_after_rel", {32'h0, pc_dbg}, 64'h3000);

    // run program A to its halt
    k = 0;
    while (!halted && k < 300) begin tick(1); k++; end
    chk("a_halted", {63'h0, halted}, 64'h1);
    exp_rd_q = '{30'hC00, 30'hC01, 30'hC02, 30'hC03, 30'hC04, 30'h002, 30'hC05, 30'hC06};
    chk("a_rd_count", rd_addr_q.size(), exp_rd_q.size());
    for (int i = 0; i < exp_rd_q.size(); i++)
      chk($sformatf("a_rd%0d", i), {34'h0, rd_at(i)}, {34'h0, exp_rd_q[i]});
    chk("alu3_cycles", cyc_at(3) - cyc_at(0), 12);
    chk("sw_cycles",   cyc_at(4) - cyc_at(3), 7);
    chk("lw_cycles",   cyc_at(6) - cyc_at(4), 8);
    exp_q.push_back({32'd2, 32'hABCD1234});
    exp_q.push_back({32'd3, 32'hABCD1234});
    chk("a_wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("a_wr%0d", i), (i < wr_q.size()) ? wr_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
    chk("a_stable", stable_err, 0);
    chk("halt_pc",    {32'h0, pc_dbg}, 64'h301C);
    chk("halt_state", {61'h0, state_dbg}, 64'h5);
    req_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mem_req) req_hi++;
    end
    chk("halt_req_low", req_hi, 0);
    chk("halt_sticky", {63'h0, halted}, 64'h1);

    // program B: bne/slt/addiu/$0/subu/and/or/j/beq loop
    Reset = 1'b0;
    tick(1);
    clear_logs();
    mem[12'hC00] = 32'h34010001;  // ori   $1,$0,1
    mem[12'hC01] = 32'h14210005;  // bne   $1,$1,+5 (not taken)
    mem[12'hC02] = 32'h2406FFFF;  // addiu $6,$0,-1
    mem[12'hC03] = 32'h24070001;  // addiu $7,$0,1
    mem[12'hC04] = 32'h00C7282A;  // slt   $5,$6,$7
    mem[12'hC05] = 32'h24000005;  // addiu $0,$0,5
    mem[12'hC06] = 32'hAC050010;  // sw    $5,16($0)
    mem[12'hC07] = 32'hAC000014;  // sw    $0,20($0)
    mem[12'hC08] = 32'h00C74023;  // subu  $8,$6,$7
    mem[12'hC09] = 32'h00C14824;  // and   $9,$6,$1
    mem[12'hC0A] = 32'h01015025;  // or    $10,$8,$1
    mem[12'hC0B] = 32'hAC080018;  // sw    $8,24($0)
    mem[12'hC0C] = 32'hAC09001C;  // sw    $9,28($0)
    mem[12'hC0D] = 32'hAC0A0020;  // sw    $10,32($0)
    mem[12'hC0E] = 32'h08000C11;  // j     0x3044
    mem[12'hC0F] = 32'hAC010024;  // sw    $1,36($0) (skipped)
    mem[12'hC10] = 32'hAC010028;  // sw    $1,40($0) (skipped)
    mem[12'hC11] = 32'h1021FFFF;  // beq   $1,$1,-1
    instr_lat = 0;
    data_lat  = 1;
    Reset = 1'b1;
    k = 0;
    while (wr_q.size() < 5 && k < 600) begin tick(1); k++; end
    tick(40);
    exp_q.push_back({32'd4, 32'h00000001});
    exp_q.push_back({32'd5, 32'h00000000});
    exp_q.push_back({32'd6, 32'hFFFFFFFE});
    exp_q.push_back({32'd7, 32'h00000001});
    exp_q.push_back({32'd8, 32'hFFFFFFFF});
    chk("b_wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("b_wr%0d", i), (i < wr_q.size()) ? wr_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
    idx = find_rd(30'hC01);
    chk("bne_fallthrough", {34'h0, rd_at(idx + 1)}, 64'hC02);
    idx = find_rd(30'hC0E);
    chk("j_target", {34'h0, rd_at(idx + 1)}, 64'hC11);
    chk("j_cycles", cyc_at(idx + 1) - cyc_at(idx), 3);
    n = rd_addr_q.size();
    chk("beq_loop_addr", {34'h0, rd_at(n - 1)}, 64'hC11);
    chk("beq_loop_prev", {34'h0, rd_at(n - 2)}, 64'hC11);
    chk("beq_loop_cycles", cyc_at(n - 1) - cyc_at(n - 2), 3);
    chk("b_no_halt", {63'h0, halted}, 64'h0);
    chk("b_stable", stable_err, 0);

    // HALT_ILL=0 core: illegal opcode behaved as a NOP
    chk("nop_no_halt", {63'h0, halted2}, 64'h0);
    chk("nop_wr_addr", {34'h0, w2_addr}, 64'h4);
    chk("nop_wr_data", {32'h0, w2_data}, 64'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
